// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and constants for the register-file write scheduler.
// The FSM state encoding and the architectural zero register live here.
package regfile_write_scheduler_pkg;

   typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after the last
// winner (ptr_i) and wraps modulo N. Produces a one-hot grant and the winner index.
module rr_arbiter
   import regfile_write_scheduler_pkg::*;
#(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] win_o,
   output logic          any_o
);

   always_comb begin
      int cand;
      gnt_o = '0;
      win_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(ptr_i) + k) % N;
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            win_o       = PW'(cand);
         end
      end
   end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the single register-file write port: zero-sweeps registers 1..2**AW-1
// after reset or on request, then shares the port round-robin among requesters.
module regfile_write_scheduler
   import regfile_write_scheduler_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int DW   = 32,
   parameter int AW   = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_reg,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 sweep_start,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_wreg,
   output logic [DW-1:0]        rf_wdata,
   output logic                 init_done
);

   localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [AW-1:0] LAST_IDX = '1;
   localparam logic [AW-1:0] FIRST_IDX = AW'(1);
   localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);

   state_e          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic            rf_we_q, rf_we_d;
   logic [AW-1:0]   rf_wreg_q, rf_wreg_d;
   logic [DW-1:0]   rf_wdata_q, rf_wdata_d;

   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   win;
   logic            gnt_any;
   logic [AW-1:0]   win_reg;
   logic [DW-1:0]   win_data;

   rr_arbiter #(
      .N  (NREQ),
      .PW (PW)
   ) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .win_o (win),
      .any_o (gnt_any)
   );

   assign win_reg  = req_reg[int'(win)*AW +: AW];
   assign win_data = req_data[int'(win)*DW +: DW];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      ptr_d      = ptr_q;
      rf_we_d    = 1'b0;
      rf_wreg_d  = rf_wreg_q;
      rf_wdata_d = rf_wdata_q;
      req_ready  = '0;
      case (state_q)
         ST_SWEEP: begin
            rf_we_d    = 1'b1;
            rf_wreg_d  = idx_q;
            rf_wdata_d = '0;
            idx_d      = idx_q + FIRST_IDX;
            if (idx_q == LAST_IDX) begin
               state_d = ST_RUN;
               idx_d   = FIRST_IDX;
            end
         end
         ST_RUN: begin
            // A sweep request suppresses this cycle's grant so nothing is lost.
            if (sweep_start) begin
               state_d = ST_SWEEP;
               idx_d   = FIRST_IDX;
            end else if (gnt_any) begin
               req_ready = gnt;
               ptr_d     = win;
               if (win_reg != AW'(ZERO_REG)) begin
                  rf_we_d    = 1'b1;
                  rf_wreg_d  = win_reg;
                  rf_wdata_d = win_data;
               end
            end
         end
         default: begin
            state_d = ST_SWEEP;
            idx_d   = FIRST_IDX;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_SWEEP;
         idx_q      <= FIRST_IDX;
         ptr_q      <= PTR_RST;
         rf_we_q    <= 1'b0;
         rf_wreg_q  <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         ptr_q      <= ptr_d;
         rf_we_q    <= rf_we_d;
         rf_wreg_q  <= rf_wreg_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_wreg   = rf_wreg_q;
   assign rf_wdata  = rf_wdata_q;
   assign init_done = (state_q == ST_RUN);

endmodule
